// File: rtl/dec3_8_strobe_pkg.sv
// Shared definitions for the encoder/decoder strobe path.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, a generic index-to-one-hot helper and a
// clog2 helper that never returns less than one bit.
package dec_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // The one-hot helper works on a fixed maximum width so that any decoder
    // instance up to 6 index bits can share it; callers truncate the result.
    localparam int ONEHOT_IDX_W = 6;
    localparam int ONEHOT_MAX_W = 1 << ONEHOT_IDX_W;

    function automatic logic [ONEHOT_MAX_W-1:0] onehot(input logic [ONEHOT_IDX_W-1:0] idx);
        logic [ONEHOT_MAX_W-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Width of a counter able to hold 'value'-1; a zero-width counter is
    // never useful, so the result is clamped to one bit.
    function automatic int clog2_min1(input int value);
        int w;
        w = $clog2(value);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dec3_8_strobe_timer.sv
// Loadable down-counter with a zero flag, used to time strobe and gap phases.
// Latency: load/decrement take effect on the next rising clk edge.
// Backpressure: none; the owner decides when to load or decrement.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   i_load       load i_load_val (has priority over i_dec)
//   i_load_val   value to load
//   i_dec        decrement by one; saturates at zero
//   o_cnt        current count
//   o_zero       count is zero
module strobe_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/dec3_8_strobe.sv
// Sequential index-to-one-hot decoder producing a fixed-width strobe plus idle gap.
// Latency: strobe appears 1 clk after acceptance; one index per 1+PULSE_LEN+GAP_LEN clks.
// Backpressure: in_ready low outside IDLE; in_valid seen while not ready is dropped, not queued.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   in_idx       encoded index, sampled only on the accepting edge
//   in_valid     in_idx is valid; source holds it until accepted
//   in_ready     block can accept this cycle (IDLE, and at least one edge out of reset)
//   out_onehot   registered one-hot strobe, zero outside the pulse
//   out_valid    high exactly while out_onehot is non-zero
//   done         one-cycle pulse on the last gap cycle (last pulse cycle if no gap)
module dec3_8_strobe
    import dec_pkg::*;
#(
    parameter int IN_W      = 3,
    parameter int OUT_W     = 8,
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in_idx,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_onehot,
    output logic             out_valid,
    output logic             done
);

    localparam int CNT_W      = clog2_min1(max2(PULSE_LEN, GAP_LEN) + 1);
    localparam int PULSE_LOAD = (PULSE_LEN > 0) ? PULSE_LEN - 1 : 0;
    localparam int GAP_LOAD   = (GAP_LEN > 0) ? GAP_LEN - 1 : 0;

    localparam logic [CNT_W-1:0] PULSE_LOAD_V = CNT_W'(PULSE_LOAD);
    localparam logic [CNT_W-1:0] GAP_LOAD_V   = CNT_W'(GAP_LOAD);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    localparam bit HAS_GAP = (GAP_LEN > 0);
    // done is registered, so it is raised on the edge that enters the final
    // cycle. These cover the case where that final cycle is the first one
    // of its phase (phase length of one).
    localparam bit DONE_ON_PULSE_LOAD = (PULSE_LEN == 1) && (GAP_LEN == 0);
    localparam bit DONE_ON_GAP_LOAD   = (GAP_LEN == 1);

    if (OUT_W != (1 << IN_W)) begin : g_chk_out_w
        $error("dec3_8_strobe: OUT_W must equal 2**IN_W");
    end
    if (IN_W > ONEHOT_IDX_W) begin : g_chk_in_w
        $error("dec3_8_strobe: IN_W exceeds the one-hot helper width");
    end
    if (PULSE_LEN < 1) begin : g_chk_pulse
        $error("dec3_8_strobe: PULSE_LEN must be >= 1");
    end
    if (GAP_LEN < 0) begin : g_chk_gap
        $error("dec3_8_strobe: GAP_LEN must be >= 0");
    end

    state_t           r_state;
    logic [IN_W-1:0]  r_idx;
    logic [OUT_W-1:0] r_onehot;
    logic             r_out_valid;
    logic             r_done;
    // Keeps in_ready low until the first edge after reset release even
    // though the FSM already sits in IDLE.
    logic             r_started;

    logic             w_accept;
    logic [OUT_W-1:0] w_in_onehot;
    logic [OUT_W-1:0] w_cap_onehot;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_dec;
    logic [CNT_W-1:0] w_cnt;
    logic             w_zero;
    logic             w_cnt_is_one;

    assign in_ready     = r_started && (r_state == IDLE);
    assign w_accept     = in_valid && in_ready;
    assign w_in_onehot  = OUT_W'(onehot(ONEHOT_IDX_W'(in_idx)));
    assign w_cap_onehot = OUT_W'(onehot(ONEHOT_IDX_W'(r_idx)));
    assign w_cnt_is_one = (w_cnt == CNT_ONE);

    // Timer control: load pulse length on acceptance, gap length at the end
    // of the pulse, otherwise count down while a phase is running.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = PULSE_LOAD_V;
        w_dec      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_load     = 1'b1;
                    w_load_val = PULSE_LOAD_V;
                end
            end
            PULSE: begin
                if (w_zero) begin
                    if (HAS_GAP) begin
                        w_load     = 1'b1;
                        w_load_val = GAP_LOAD_V;
                    end
                end else begin
                    w_dec = 1'b1;
                end
            end
            GAP: begin
                w_dec = !w_zero;
            end
            default: begin
                w_dec = 1'b0;
            end
        endcase
    end

    strobe_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_cnt      (w_cnt),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_onehot    <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_started   <= 1'b0;
        end else begin
            r_started <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_idx       <= in_idx;
                        r_onehot    <= w_in_onehot;
                        r_out_valid <= 1'b1;
                        r_done      <= DONE_ON_PULSE_LOAD;
                        r_state     <= PULSE;
                    end else begin
                        r_onehot    <= '0;
                        r_out_valid <= 1'b0;
                        r_done      <= 1'b0;
                    end
                end
                PULSE: begin
                    if (w_zero) begin
                        r_onehot    <= '0;
                        r_out_valid <= 1'b0;
                        if (HAS_GAP) begin
                            r_state <= GAP;
                            r_done  <= DONE_ON_GAP_LOAD;
                        end else begin
                            r_state <= IDLE;
                            r_done  <= 1'b0;
                        end
                    end else begin
                        // Re-derived from the captured index every cycle so
                        // the strobe cannot drift from what was accepted.
                        r_onehot    <= w_cap_onehot;
                        r_out_valid <= 1'b1;
                        r_done      <= !HAS_GAP && w_cnt_is_one;
                    end
                end
                GAP: begin
                    r_onehot    <= '0;
                    r_out_valid <= 1'b0;
                    if (w_zero) begin
                        r_state <= IDLE;
                        r_done  <= 1'b0;
                    end else begin
                        r_done  <= w_cnt_is_one;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_onehot    <= '0;
                    r_out_valid <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    assign out_onehot = r_onehot;
    assign out_valid  = r_out_valid;
    assign done       = r_done;

endmodule

// File: doc/dec3_8_strobe.md
Name: dec3_8_strobe

Overview:
- Sequential 3-to-8 decoder: the return path for the 8-to-3 priority encoder (index + valid in, one-hot out).
- Accepts an encoded index over a valid/ready handshake, registers it, and drives the matching one-hot line for a programmable number of cycles.
- An enforced idle gap follows each strobe.
- Sits between encoder-fed arbitration logic and per-line consumers (enables, acknowledges, LED/strobe drivers) that need a clean, glitch-free, fixed-width pulse.

Parameters:
- IN_W, 3, encoded index width.
- OUT_W, 8, one-hot width. Must equal 2**IN_W; elaboration error otherwise.
- PULSE_LEN, 4, cycles the one-hot output is held. Must be >= 1; elaboration error if 0.
- GAP_LEN, 1, all-zero cycles forced after each pulse. 0 is legal: no gap.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_idx  input  IN_W  encoded index to decode.
- in_valid  input  1  in_idx is valid (mirrors the encoder's valid output).
- in_ready  output  1  block can accept a new index this cycle.
- out_onehot  output  OUT_W  registered one-hot strobe. All zeros when not pulsing.
- out_valid  output  1  high exactly while out_onehot is non-zero.
- done  output  1  one-cycle pulse on the last cycle of the gap. If GAP_LEN=0, on the last pulse cycle.

Behaviour:
- Interface (already decided): one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values (async on rst_n low):
  - state=IDLE, counter=0, captured idx=0.
  - out_onehot=0, out_valid=0, done=0, in_ready=0 while rst_n low.
  - in_ready=1 from the first clk edge after rst_n deasserts.
- All outputs are registered except in_ready, which is a decode of state (in_ready = state==IDLE).
- FSM states: IDLE, PULSE, GAP.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: capture in_idx, load counter=PULSE_LEN-1, go to PULSE.
  - in_valid=0: remain in IDLE, outputs 0.
- PULSE:
  - out_onehot = 1 << idx_captured; out_valid=1. Both appear on the cycle after acceptance, so latency is 1 clock.
  - Counter decrements each cycle.
  - At counter==0: if GAP_LEN>0, load counter=GAP_LEN-1 and go to GAP; else assert done and go to IDLE.
  - Exactly PULSE_LEN cycles of out_valid per accepted index.
- GAP:
  - out_onehot=0, out_valid=0; counter decrements.
  - At counter==0: assert done and go to IDLE.
  - Exactly GAP_LEN cycles.
- Handshake:
  - in_idx is sampled only on the accepting edge; later changes to in_idx have no effect.
  - in_valid while in_ready=0 is ignored, not queued. The source must hold it until accepted.
- Throughput: one index per 1+PULSE_LEN+GAP_LEN cycles. Back-to-back in_valid gets re-accepted on the first IDLE cycle.
- Counter width: $clog2 of max(PULSE_LEN,GAP_LEN)+1, minimum 1 bit. No wrap-around is possible.
- out_onehot has exactly one bit set whenever out_valid=1. Index 7 gives 8'b1000_0000; index 0 gives 8'b0000_0001.
- Reset mid-PULSE or mid-GAP: outputs clear immediately (asynchronously), the FSM returns to IDLE, and done is not asserted.
- done and in_ready are never high in the same cycle. The cycle after done, in_ready=1.

Decomposition:
- Shared package dec_pkg:
  - FSM state enum constants: IDLE=2'd0, PULSE=2'd1, GAP=2'd2.
  - Function onehot(idx) returning OUT_W bits.
  - clog2 helper, reused by the encoder side.
- One natural sub-module: strobe_timer. Loadable down-counter with a zero flag, instantiated once and reloaded with PULSE_LEN-1 or GAP_LEN-1.
- The decode itself stays inline.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1, in_idx=5 -> out_onehot=0, out_valid=0, in_ready=0. First edge after release -> in_ready=1.
- Single decode, defaults: in_idx=3, in_valid=1 for one cycle -> next cycle out_onehot=8'b0000_1000 for exactly 4 cycles, then 1 zero cycle with done=1, then in_ready=1.
- Sweep: in_idx 0..7 back-to-back with in_valid held high -> each value yields one 4-cycle strobe at bit idx, in order. Acceptances are spaced 6 cycles apart. No bit other than idx is ever set.
- Ignored input: during a PULSE of idx=1, change in_idx to 6 and toggle in_valid -> strobe stays 8'b0000_0010. Idx 6 is accepted only once in_ready returns.
- Async reset mid-pulse: assert rst_n=0 on the 2nd PULSE cycle of idx=7 -> out_onehot goes to 0 before the next clk edge, and done never pulses.
- Parameter corners: PULSE_LEN=1, GAP_LEN=0, idx=4 -> 8'b0001_0000 for one cycle with done=1 in that same cycle, then in_ready=1 on the following cycle.
